// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants shared by the sync generator, display and game logic.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 8;

    localparam int H_VISIBLE_AREA = 640;
    localparam int H_FRONT_PORCH  = 16;
    localparam int H_SYNC_PULSE   = 96;
    localparam int H_BACK_PORCH   = 48;
    localparam int H_TOTAL        = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

    localparam int V_VISIBLE_AREA = 480;
    localparam int V_FRONT_PORCH  = 10;
    localparam int V_SYNC_PULSE   = 2;
    localparam int V_BACK_PORCH   = 33;
    localparam int V_TOTAL        = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam int SYNC_DELAY      = 2;
    localparam int SYNC_ACTIVE_LOW = 1;

    typedef struct packed {
        logic v;
        logic h;
    } sync_t;

    function automatic logic in_range(input logic [CNT_W-1:0] x, input int lo, input int hi);
        return (int'(x) >= lo) && (int'(x) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// H/V counter and sync bundle between the timing generator and its consumers.
interface vga_sync_generator_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0]   o_H_Counter;
    logic [CNT_W-1:0]   o_V_Counter;
    logic               o_HSync;
    logic               o_VSync;
    logic               o_Visible;
    logic               o_Line_Start;
    logic               o_Frame_Start;
    logic [FRAME_W-1:0] o_Frame_Count;

    modport master (
        output o_H_Counter, o_V_Counter, o_HSync, o_VSync,
               o_Visible, o_Line_Start, o_Frame_Start, o_Frame_Count
    );

    modport slave (
        input  o_H_Counter, o_V_Counter, o_HSync, o_VSync,
               o_Visible, o_Line_Start, o_Frame_Start, o_Frame_Count
    );
endinterface

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with async reset to RESET_VALUE; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int               WIDTH       = 2,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

        always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
                pipe_q <= {DEPTH{RESET_VALUE}};
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_generator.sv
// Free-running VGA timing generator: H/V counters, delayed syncs, visible flag, strobes.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE_AREA  = vga_timing_pkg::H_VISIBLE_AREA,
    parameter int H_FRONT_PORCH   = vga_timing_pkg::H_FRONT_PORCH,
    parameter int H_SYNC_PULSE    = vga_timing_pkg::H_SYNC_PULSE,
    parameter int H_BACK_PORCH    = vga_timing_pkg::H_BACK_PORCH,
    parameter int V_VISIBLE_AREA  = vga_timing_pkg::V_VISIBLE_AREA,
    parameter int V_FRONT_PORCH   = vga_timing_pkg::V_FRONT_PORCH,
    parameter int V_SYNC_PULSE    = vga_timing_pkg::V_SYNC_PULSE,
    parameter int V_BACK_PORCH    = vga_timing_pkg::V_BACK_PORCH,
    parameter int SYNC_DELAY      = vga_timing_pkg::SYNC_DELAY,
    parameter int SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    vga_sync_generator_if.master vga_o
);

    localparam int HT       = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int VT       = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
    localparam int VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);

    if (HT > 1024 || VT > 1024) begin : g_bad_total
        $error("vga_sync_generator: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_sync_generator: SYNC_DELAY must be in 0..7");
    end

    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    sync_t              sync_raw, sync_dly;

    always_comb begin
        h_d     = h_q + 1'b1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d     = '0;
                frame_d = frame_q + 1'b1;
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // Raw syncs are active-high; polarity is applied after the delay so the
    // flushed (reset) stages always read as inactive.
    assign sync_raw.h = in_range(h_q, HS_START, HS_START + H_SYNC_PULSE - 1);
    assign sync_raw.v = in_range(v_q, VS_START, VS_START + V_SYNC_PULSE - 1);

    sync_delay_line #(
        .WIDTH       (2),
        .DEPTH       (SYNC_DELAY),
        .RESET_VALUE (2'b00)
    ) u_sync_dly (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .d_i     (sync_raw),
        .q_o     (sync_dly)
    );

    assign vga_o.o_HSync       = (SYNC_ACTIVE_LOW != 0) ? ~sync_dly.h : sync_dly.h;
    assign vga_o.o_VSync       = (SYNC_ACTIVE_LOW != 0) ? ~sync_dly.v : sync_dly.v;
    assign vga_o.o_H_Counter   = h_q;
    assign vga_o.o_V_Counter   = v_q;
    assign vga_o.o_Frame_Count = frame_q;
    assign vga_o.o_Visible     = (int'(h_q) < H_VISIBLE_AREA) && (int'(v_q) < V_VISIBLE_AREA);
    assign vga_o.o_Line_Start  = (h_q == '0);
    assign vga_o.o_Frame_Start = (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: full-size 640x480 instance plus a shrunken-timing instance for frame wrap.
module tb_vga_sync_generator;

    // shrunken timing so 256 frames fit in a short run
    localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVV = 6, BVF = 1, BVS = 2, BVB = 1;
    localparam int BD  = 3, BAL = 0;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, d, al;
    } tp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    longint n  = 0;
    bit    done = 1'b0;
    int    tests = 0;
    int    fails = 0;
    tp_t   pa, pb;
    exp_t  qa[$];
    exp_t  qb[$];

    always #5 clk = ~clk;

    vga_sync_generator_if ifa ();
    vga_sync_generator_if ifb ();

    vga_sync_generator u_dut_a (
        .i_Clk   (clk),
        .i_Reset (rst),
        .vga_o   (ifa)
    );

    vga_sync_generator #(
        .H_VISIBLE_AREA (BHV), .H_FRONT_PORCH (BHF), .H_SYNC_PULSE (BHS), .H_BACK_PORCH (BHB),
        .V_VISIBLE_AREA (BVV), .V_FRONT_PORCH (BVF), .V_SYNC_PULSE (BVS), .V_BACK_PORCH (BVB),
        .SYNC_DELAY     (BD),  .SYNC_ACTIVE_LOW (BAL)
    ) u_dut_b (
        .i_Clk   (clk),
        .i_Reset (rst),
        .vga_o   (ifb)
    );

    // Expected outputs n clocks after reset release, from the timing rules directly.
    function automatic exp_t model(input tp_t p, input longint cyc, input bit r);
        exp_t   e;
        longint ht, vt, hh, vv, m, mh, mv;
        bit     ah, av;
        ht = p.hv + p.hf + p.hs + p.hb;
        vt = p.vv + p.vf + p.vs + p.vb;
        if (r) begin
            e = '{h: 10'd0, v: 10'd0, hs: (p.al != 0), vs: (p.al != 0),
                  vis: 1'b1, ls: 1'b1, fs: 1'b1, fc: 8'd0};
            return e;
        end
        hh = cyc % ht;
        vv = (cyc / ht) % vt;
        e.h   = 10'(hh);
        e.v   = 10'(vv);
        e.vis = (hh < p.hv) && (vv < p.vv);
        e.ls  = (hh == 0);
        e.fs  = (hh == 0) && (vv == 0);
        e.fc  = 8'((cyc / (ht * vt)) % 256);
        m  = cyc - p.d;
        ah = 1'b0;
        av = 1'b0;
        if (m >= 0) begin
            mh = m % ht;
            mv = (m / ht) % vt;
            ah = (mh >= p.hv + p.hf) && (mh < p.hv + p.hf + p.hs);
            av = (mv >= p.vv + p.vf) && (mv < p.vv + p.vf + p.vs);
        end
        e.hs = (p.al != 0) ? !ah : ah;
        e.vs = (p.al != 0) ? !av : av;
        return e;
    endfunction

    function automatic exp_t sample_a();
        return '{h: ifa.o_H_Counter, v: ifa.o_V_Counter, hs: ifa.o_HSync, vs: ifa.o_VSync,
                 vis: ifa.o_Visible, ls: ifa.o_Line_Start, fs: ifa.o_Frame_Start,
                 fc: ifa.o_Frame_Count};
    endfunction

    function automatic exp_t sample_b();
        return '{h: ifb.o_H_Counter, v: ifb.o_V_Counter, hs: ifb.o_HSync, vs: ifb.o_VSync,
                 vis: ifb.o_Visible, ls: ifb.o_Line_Start, fs: ifb.o_Frame_Start,
                 fc: ifb.o_Frame_Count};
    endfunction

    task automatic cmp(input string nm, input exp_t got, input exp_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d",
                     nm, $time, got.h, got.v, got.hs, got.vs, got.vis, got.ls, got.fs, got.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.vis, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
        end
    endtask

    // One clock: advance the cycle index, apply reset for the next cycle, queue expectations.
    task automatic step(input bit r);
        @(posedge clk);
        if (!rst) n++;
        #2;
        rst = r;
        if (r) n = 0;
        qa.push_back(model(pa, n, r));
        qb.push_back(model(pb, n, r));
    endtask

    // Assert reset between edges and check that it takes effect without a clock.
    task automatic async_reset(input bit expect_b_sync);
        #5;
        if (expect_b_sync) begin
            chk("b_sync_active_pre_rst", {30'd0, ifb.o_HSync, ifb.o_VSync}, 32'd3);
        end
        rst = 1'b1;
        n   = 0;
        #1;
        chk("a_async_rst_cnt",  {12'd0, ifa.o_H_Counter, ifa.o_V_Counter}, 32'd0);
        chk("a_async_rst_sync", {30'd0, ifa.o_HSync, ifa.o_VSync}, 32'd3);
        chk("b_async_rst_cnt",  {12'd0, ifb.o_H_Counter, ifb.o_V_Counter}, 32'd0);
        chk("b_async_rst_sync", {30'd0, ifb.o_HSync, ifb.o_VSync}, 32'd0);
    endtask

    // Monitor: every output cycle is compared against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_underflow t=%0t", $time);
                end else begin
                    cmp("dut_a", sample_a(), qa.pop_front());
                    cmp("dut_b", sample_b(), qb.pop_front());
                end
            end
        end
    end

    initial begin
        int k;
        pa = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1};
        pb = '{BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BD, BAL};

        repeat (5) step(1'b1);
        step(1'b0);

        // small instance reaches a point where both delayed syncs are active
        repeat (119) step(1'b0);
        async_reset(1'b1);
        repeat (2) step(1'b1);
        step(1'b0);

        // 256+ shrunken frames (frame counter wrap); full-size instance covers its first lines
        repeat (38600) step(1'b0);

        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(1, 300);
            repeat (k) step(1'b0);
            async_reset(1'b0);
            k = $urandom_range(0, 3);
            repeat (k) step(1'b1);
            step(1'b0);
        end
        repeat (900) step(1'b0);

        @(negedge clk);
        #1;
        done = 1'b1;
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
Free-running VGA 640x480@60 Hz timing generator. It is the producer end of the H/V counter interface that the sprite display consumes.
- Emits horizontal and vertical pixel counters, HSync/VSync, a visible-area flag and frame/line strobes.
- HSync/VSync are delayed by a parameterised pipeline depth so they stay aligned with the display's registered pixel output.

Parameters:
H_VISIBLE_AREA, 640, active pixels per line
H_FRONT_PORCH, 16, pixels after visible area before HSync
H_SYNC_PULSE, 96, HSync width in pixels
H_BACK_PORCH, 48, pixels after HSync
V_VISIBLE_AREA, 480, active lines per frame
V_FRONT_PORCH, 10, lines after visible area before VSync
V_SYNC_PULSE, 2, VSync width in lines
V_BACK_PORCH, 33, lines after VSync
SYNC_DELAY, 2, clock cycles HSync/VSync lag the counters (0..7)
SYNC_ACTIVE_LOW, 1, 1 = sync asserted low, 0 = asserted high

Ports:
i_Clk  input  1  pixel clock (25 MHz); the block's only clock
i_Reset  input  1  asynchronous, active-high reset
o_H_Counter  output  10  current column, 0..H_TOTAL-1
o_V_Counter  output  10  current line, 0..V_TOTAL-1
o_HSync  output  1  horizontal sync, delayed SYNC_DELAY cycles
o_VSync  output  1  vertical sync, delayed SYNC_DELAY cycles
o_Visible  output  1  counters inside the visible area (undelayed)
o_Line_Start  output  1  one-cycle pulse when o_H_Counter==0
o_Frame_Start  output  1  one-cycle pulse when both counters==0
o_Frame_Count  output  8  frames completed, wraps 255->0

Behaviour:
- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525). Both must be <=1024; elaboration fails otherwise.
- Reset values (asynchronous):
  - counters 0, o_Frame_Count 0.
  - o_HSync/o_VSync at their inactive level (1 when SYNC_ACTIVE_LOW=1), including every delay-line stage.
  - o_Visible, o_Line_Start and o_Frame_Start are combinational decodes of the counters, so they read 1 during reset (counters at 0,0).
- Counters are registered; every cycle:
  - If H==H_TOTAL-1: H<=0.
    - If also V==V_TOTAL-1: V<=0 and o_Frame_Count increments (mod 256).
    - Otherwise V<=V+1.
  - Otherwise H<=H+1.
  - No enable: the block free-runs.
- Raw sync decode, from the registered counters:
  - HSync active for H in [H_VISIBLE_AREA+H_FRONT_PORCH, H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE-1], i.e. [656,751].
  - VSync active for V in [V_VISIBLE_AREA+V_FRONT_PORCH, V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE-1], i.e. [490,491], for the whole line.
- Sync delay line:
  - Raw syncs pass through a SYNC_DELAY-deep shift register.
  - SYNC_DELAY=0 gives combinational pass-through of the raw decode.
  - Polarity is applied after the delay.
- o_Visible = (H<H_VISIBLE_AREA)&&(V<V_VISIBLE_AREA). It is not delayed, because the display uses it together with the counters.
- o_Line_Start / o_Frame_Start:
  - Decoded from the counters in the same cycle.
  - Both fire in the first cycle after reset release, since the counters are at 0,0.
- Frame-wrap cycle (799,524)->(0,0):
  - o_Frame_Start, o_Line_Start and the o_Frame_Count increment all become visible in the same cycle.
- Reset mid-frame:
  - Counters return to 0 immediately and the delay line is flushed to inactive.
  - No partial sync pulse may appear after release.

Decomposition:
- Shared package/include vga_timing_pkg:
  - 640x480 timing constants, H_TOTAL, V_TOTAL.
  - Sync polarity constant.
  - Visible-area constants, also consumed by the display and game-logic blocks.
- One sub-module, sync_delay_line:
  - Parameterised WIDTH x DEPTH shift register with asynchronous reset to a parameterised RESET_VALUE.
  - Instantiated once (WIDTH=2) for HSync/VSync.

Test Plan:
- Reset held 5 cycles, then released -> during reset H=V=0, o_HSync=o_VSync=1, o_Frame_Count=0; first released cycle o_Frame_Start=1 and o_Line_Start=1.
- Run one line -> H counts 0..799 then 0, V 0->1 exactly at the wrap; o_Line_Start high only at H=0; o_Visible falls at H=640.
- SYNC_DELAY=2, line 0 -> o_HSync low first in the cycle where o_H_Counter=658, high again at o_H_Counter=754 (96 cycles low).
- Full frame -> o_VSync low for exactly 2x800 cycles, starting 2 cycles after (H=0,V=490); at (799,524)->(0,0) o_Frame_Start pulses and o_Frame_Count goes 0->1.
- 256 frames -> o_Frame_Count wraps 255->0 on the frame-start cycle.
- Reset asserted at (H=700,V=491) with syncs active -> syncs go inactive asynchronously and counters 0; after release no sync edge until H reaches 656+SYNC_DELAY.
